muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit, one stage downstream of the register file read ports.
- Consumes rs1_data/rs2_data for an M-extension instruction and produces one 32-bit result plus destination index and write strobe.
- Outputs go to the register file write port (data/rd/reg_write), which writes on the falling clock edge.
- Stalls the pipeline via busy while computing.

---
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up and single-cycle special-case bypass.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);

  localparam int CW = $clog2(ITER);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_SIGN   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] m_op;        // multiplicand (mul) or divisor (div), fixed during CALC
  logic [XLEN-1:0] p_hi, p_lo;  // product hi/lo, or remainder/quotient
  logic            neg_q, neg_r, bypass;

  // operand decode at accept time
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] spec_val;

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = is_div ? ~funct3[0] : (funct3[1:0] != 2'd3);
    b_sgn    = is_div ? ~funct3[0] : ~funct3[1];
    a_neg    = a_sgn & rs1_data[XLEN-1];
    b_neg    = b_sgn & rs2_data[XLEN-1];
    a_abs    = a_neg ? -rs1_data : rs1_data;
    b_abs    = b_neg ? -rs2_data : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    div_ovf  = is_div && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
               && (rs2_data == '1);
    spec_val = '0;
    if (div_zero)     spec_val = funct3[1] ? rs1_data : '1;
    else if (div_ovf) spec_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // one iteration of each datapath
  logic [XLEN:0] mul_sum, div_sh, div_df;
  always_comb begin
    mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m_op} : '0);
    div_sh  = {p_hi, p_lo[XLEN-1]};
    div_df  = div_sh - {1'b0, m_op};
  end

  // sign fix-up and result select
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin;
  always_comb begin
    prod_s = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};
    quo_s  = neg_q ? -p_lo : p_lo;
    rem_s  = neg_r ? -p_hi : p_hi;
    if (bypass)          fin = p_lo;
    else if (!op[2])     fin = (op[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else if (op[1])      fin = rem_s;
    else                 fin = quo_s;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op        <= '0;
      rd_q      <= '0;
      m_op      <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      bypass    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reg_write <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op     <= funct3;
          rd_q   <= rd_in;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          busy   <= 1'b1;
          cnt    <= '0;
          p_hi   <= '0;
          m_op   <= is_div ? b_abs : a_abs;
          if (div_zero || div_ovf) begin
            bypass <= 1'b1;
            p_lo   <= spec_val;
            state  <= S_SIGN;
          end else begin
            bypass <= 1'b0;
            p_lo   <= is_div ? a_abs : b_abs;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (!op[2]) begin
            p_hi <= mul_sum[XLEN:1];
            p_lo <= {mul_sum[0], p_lo[XLEN-1:1]};
          end else if (!div_df[XLEN]) begin
            p_hi <= div_df[XLEN-1:0];
            p_lo <= {p_lo[XLEN-2:0], 1'b1};
          end else begin
            p_hi <= div_sh[XLEN-1:0];
            p_lo <= {p_lo[XLEN-2:0], 1'b0};
          end
          if (cnt == CW'(ITER-1)) begin
            cnt   <= '0;
            state <= S_SIGN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // result and rd land together so the falling-edge write sees a stable pair
        S_SIGN: begin
          result    <= fin;
          rd_out    <= rd_q;
          done      <= 1'b1;
          reg_write <= (rd_q != 5'd0);
          state     <= S_FINISH;
        end
        default: begin
          done      <= 1'b0;
          reg_write <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases plus random ops checked
// against plain-arithmetic reference results, latency and busy window.
module tb_muldiv_unit;
  logic        clock = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done, reg_write;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clock(clock), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out),
    .reg_write(reg_write)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    longint      lat;
    longint      acc;
  } item_t;

  item_t q[$];
  int n_total = 0, n_pass = 0;
  int bcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // reference: widen to 64 bits and use native arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (!f[2]) begin
      ea = (f != 3'd3) ? {{32{a[31]}}, a} : {32'd0, a};
      eb = (f <= 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return (f == 3'd0) ? p[31:0] : p[63:32];
    end
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f[1] ? 32'd0 : 32'h8000_0000;
    case (f)
      3'd4:    return 32'(sa / sb);
      3'd5:    return a / b;
      3'd6:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return $urandom_range(0, 100);
      default: return $urandom;
    endcase
  endfunction

  // waits for idle at a falling edge, then pulses start for one cycle
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    item_t it;
    int n = 0;
    while (busy && n < 100) begin @(negedge clock); n++; end
    if (busy) chk("issue_wait_idle", 64'(busy), 64'd0);
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    it.res = ref_model(f, a, b);
    it.rd  = rd;
    it.we  = (rd != 0);
    it.lat = is_special(f, a, b) ? 1 : 33;
    it.acc = longint'($time) + 5;
    q.push_back(it);
    @(negedge clock);
    start = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
  endtask

  always @(negedge clock) begin
    if (reset) bcnt = 0;
    else begin
      if (busy) bcnt++;
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          item_t it;
          it = q.pop_front();
          chk("result", 64'(result), 64'(it.res));
          chk("rd_out", 64'(rd_out), 64'(it.rd));
          chk("reg_write", 64'(reg_write), 64'(it.we));
          chk("latency", 64'((longint'($time) - it.acc - 5) / 10), 64'(it.lat));
          chk("busy_cycles", 64'(bcnt), 64'(it.lat + 1));
        end
        bcnt = 0;
      end
    end
  end

  logic [2:0]  d_f[14]  = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                            3'd5, 3'd6, 3'd4, 3'd6, 3'd0, 3'd7};
  logic [31:0] d_a[14]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100,
                            32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
  logic [31:0] d_b[14]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'd3, 32'd3, 32'd7, 32'd7, 32'd0, 32'd0,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd6, 32'd0};
  logic [4:0]  d_rd[14] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8,
                            5'd9, 5'd10, 5'd11, 5'd12, 5'd0, 5'd13};

  initial begin
    reset = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_rd_out", 64'(rd_out), 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 14; i++) issue(d_f[i], d_a[i], d_b[i], d_rd[i]);

    // a start pulse while busy must be dropped
    issue(3'd5, 32'd1000, 32'd9, 5'd20);
    repeat (9) @(negedge clock);
    chk("busy_mid_op", 64'(busy), 64'd1);
    funct3 = 3'd0; rs1_data = 32'd2; rs2_data = 32'd2; rd_in = 5'd21; start = 1'b1;
    @(negedge clock);
    start = 1'b0;

    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 5'($urandom));

    // asynchronous reset in the middle of CALC
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17);
    repeat (14) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("abort_no_done_busy", 64'(busy), 64'd0);
    issue(3'd0, 32'd3, 32'd4, 5'd22);

    begin
      int n = 0;
      while (q.size() != 0 && n < 200) begin @(negedge clock); n++; end
      if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    end
    repeat (5) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
